acc_mat_bridge: RTL and testbench
=================================

// Module: acc_mat_bridge
// PURPOSE
//  Memory-mapped bridge between the core data bus and the matrix accelerator (top_acc).
//  Holds operand matrices A and B, launches the accelerator, captures result C on completion.
//  Exposes a control/status register so software can start, poll, clear and re-run.
//  Generalised in element width, matrix size and address base, with a real run FSM and handshake.
// PARAMETERS
//  DATA_W  8     element width in bits (1..32)
//  N_ELEM  1024  elements per matrix (power of 2, >=4)
//  ADDR_W  32    bus address width
//  BASE    0     region base; CTRL=BASE+N_ELEM-2, STAT=BASE+N_ELEM-1,
//                A=BASE+N_ELEM.., B=BASE+2*N_ELEM.., C=BASE+3*N_ELEM.. (N_ELEM entries each)
// PORTS
//  clk         in   1              clock, all logic on posedge
//  rst         in   1              synchronous reset, active high
//  req_i       in   1              bus request
//  we_i        in   1              1=write, 0=read
//  addr_i      in   ADDR_W         element/register address
//  wdata_i     in   32             write data; low DATA_W bits used for A/B
//  gnt_o       out  1              request accepted (same cycle, combinational)
//  rvalid_o    out  1              response valid, one cycle after gnt
//  rdata_o     out  32             read data, valid with rvalid_o
//  err_o       out  1              response error, valid with rvalid_o
//  acc_start_o out  1              one-cycle start pulse to accelerator
//  acc_done_i  in   1              accelerator completion pulse
//  acc_in_a_o  out  N_ELEM*DATA_W  matrix A, element i at [i*DATA_W +: DATA_W]
//  acc_in_b_o  out  N_ELEM*DATA_W  matrix B, same packing
//  acc_out_i   in   N_ELEM*DATA_W  matrix C from accelerator, same packing
//  busy_o      out  1              FSM in RUN
//  irq_o       out  1              level: done flag AND irq-enable
// BEHAVIOUR
//  Reset: all outputs 0; A, B, C buffers cleared to 0; FSM=IDLE; done, irq_en, error cleared.
//  Bus: gnt_o=req_i (always accepted). rvalid_o asserted exactly 1 cycle after every granted
//   req, read or write. Reads return registered data; unused high bits of rdata_o are 0.
//  Decode: addr in [lo,lo+N_ELEM) uses index addr-lo. Unmapped address -> err_o=1,
//   write dropped, rdata_o=0.
//  CTRL write: bit0 START, bit1 CLR_DONE, bit2 IRQ_EN (stored). CTRL read: {29'b0,irq_en,2'b0}.
//  STAT read: bit0 busy, bit1 done, bit2 sticky err (cleared by CLR_DONE).
//  FSM IDLE -> RUN on START write: acc_start_o=1 for exactly the following cycle; done cleared.
//  RUN -> DONE on acc_done_i: same edge C buffer <= acc_out_i, done<=1.
//  DONE -> RUN on START (re-run without clear allowed); DONE -> IDLE on CLR_DONE.
//  START+CLR_DONE in one write: clear applies, then start (FSM -> RUN, done=0).
//  START while RUN: ignored, err_o=1, sticky err set.
//  Writes to A/B while RUN: dropped, err_o=1. Writes to C region: always err_o=1.
//  Reads of A/B/C allowed in any state; C reads during RUN return previous result.
//  acc_done_i outside RUN: ignored, C unchanged.
//  A/B writes truncate wdata_i to DATA_W bits; C reads zero-extend.
//  rst mid-RUN: FSM to IDLE, buffers cleared, later acc_done_i ignored until next START.
// TESTING
//  1 Reset then read STAT, A[0], C[N_ELEM-1] -> all 0, rvalid 1 cycle after req, err 0.
//  2 Write A[5]=0x1A5, B[N_ELEM-1]=0x3C -> acc_in_a_o elem5=0xA5 (DATA_W=8), elem N_ELEM-1 of B=0x3C.
//  3 START -> acc_start_o high exactly 1 cycle, busy_o=1; drive acc_done_i with C[3]=0x7E ->
//    STAT=0x2, read C[3]=0x7E; with IRQ_EN set irq_o=1 until CLR_DONE.
//  4 During RUN write A[0]=0x11 and START -> both err_o=1, A[0] unchanged, STAT bit2=1.
//  5 Read addr BASE+4*N_ELEM and write C[0] -> err_o=1, rdata_o=0, C unchanged.
//  6 Assert rst mid-RUN, then pulse acc_done_i -> STAT=0, C stays 0; rerun with DATA_W=16,N_ELEM=16.

Source files
------------

// File: rtl/acc_mat_bridge.sv
// Bus-mapped bridge that owns the A/B operand buffers and C result buffer of the matrix
// accelerator, plus a CTRL/STAT register pair driving a start/run/done handshake.
module acc_mat_bridge #(
  parameter int                DATA_W = 8,
  parameter int                N_ELEM = 1024,
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     acc_start_o,
  input  logic                     acc_done_i,
  output logic [N_ELEM*DATA_W-1:0] acc_in_a_o,
  output logic [N_ELEM*DATA_W-1:0] acc_in_b_o,
  input  logic [N_ELEM*DATA_W-1:0] acc_out_i,
  output logic                     busy_o,
  output logic                     irq_o
);

  localparam int                IDX_W    = $clog2(N_ELEM);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(4 * N_ELEM);
  localparam logic [IDX_W-1:0]  CTRL_IDX = IDX_W'(N_ELEM - 2);
  localparam logic [IDX_W-1:0]  STAT_IDX = IDX_W'(N_ELEM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic        done_reg;
  logic        err_flag_reg;
  logic        irq_en_reg;
  logic        acc_start_reg;
  logic        rvalid_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  // Decode: the region is the two bits above the element index, relative to BASE.
  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic [1:0]        region;
  logic [IDX_W-1:0]  idx;
  logic              hit_ctrl, hit_stat, hit_a, hit_b, hit_c, mapped;

  assign off      = addr_i - BASE;
  assign in_range = (addr_i >= BASE) && (off < SPAN);
  assign region   = off[IDX_W+1:IDX_W];
  assign idx      = off[IDX_W-1:0];
  assign hit_ctrl = in_range && (region == 2'd0) && (idx == CTRL_IDX);
  assign hit_stat = in_range && (region == 2'd0) && (idx == STAT_IDX);
  assign hit_a    = in_range && (region == 2'd1);
  assign hit_b    = in_range && (region == 2'd2);
  assign hit_c    = in_range && (region == 2'd3);
  assign mapped   = hit_ctrl || hit_stat || hit_a || hit_b || hit_c;

  logic run, wr, ctrl_wr, start_req, clr_req, start_ok, start_bad, a_wr, b_wr, c_cap;

  assign run       = (state_reg == ST_RUN);
  assign wr        = req_i && we_i;
  assign ctrl_wr   = wr && hit_ctrl;
  assign start_req = ctrl_wr && wdata_i[0];
  assign clr_req   = ctrl_wr && wdata_i[1];
  assign start_ok  = start_req && !run;
  assign start_bad = start_req && run;
  assign a_wr      = wr && hit_a && !run;
  assign b_wr      = wr && hit_b && !run;
  assign c_cap     = run && acc_done_i;

  logic [DATA_W-1:0] a_view [N_ELEM];
  logic [DATA_W-1:0] b_view [N_ELEM];
  logic [DATA_W-1:0] c_view [N_ELEM];

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
      logic [DATA_W-1:0] a_reg;
      logic [DATA_W-1:0] b_reg;
      logic [DATA_W-1:0] c_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
          c_reg <= '0;
        end else begin
          if (a_wr && (idx == IDX_W'(gi))) a_reg <= wdata_i[DATA_W-1:0];
          if (b_wr && (idx == IDX_W'(gi))) b_reg <= wdata_i[DATA_W-1:0];
          if (c_cap) c_reg <= acc_out_i[gi*DATA_W +: DATA_W];
        end
      end

      assign acc_in_a_o[gi*DATA_W +: DATA_W] = a_reg;
      assign acc_in_b_o[gi*DATA_W +: DATA_W] = b_reg;
      assign a_view[gi] = a_reg;
      assign b_view[gi] = b_reg;
      assign c_view[gi] = c_reg;
    end
  endgenerate

  logic [31:0] rdata_next;
  logic        err_next;

  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    if (!mapped) begin
      err_next = 1'b1;
    end else if (we_i) begin
      if (hit_stat || hit_c)          err_next = 1'b1;
      if ((hit_a || hit_b) && run)    err_next = 1'b1;
      if (start_bad)                  err_next = 1'b1;
    end else begin
      if (hit_ctrl)      rdata_next = {29'd0, irq_en_reg, 2'b00};
      else if (hit_stat) rdata_next = {29'd0, err_flag_reg, done_reg, run};
      else if (hit_a)    rdata_next = 32'(a_view[idx]);
      else if (hit_b)    rdata_next = 32'(b_view[idx]);
      else if (hit_c)    rdata_next = 32'(c_view[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      done_reg      <= 1'b0;
      err_flag_reg  <= 1'b0;
      irq_en_reg    <= 1'b0;
      acc_start_reg <= 1'b0;
      rvalid_reg    <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      rvalid_reg    <= req_i;
      err_reg       <= req_i && err_next;
      rdata_reg     <= req_i ? rdata_next : 32'd0;
      acc_start_reg <= start_ok;

      if (ctrl_wr) irq_en_reg <= wdata_i[2];

      // Clear first so a combined CLR_DONE+START write (or a rejected START) wins afterwards.
      if (clr_req)   begin done_reg <= 1'b0; err_flag_reg <= 1'b0; end
      if (start_bad) err_flag_reg <= 1'b1;

      unique case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (acc_done_i) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start_ok) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
          end else if (clr_req) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // High wdata bits only matter for CTRL and wide elements.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_reg;
  assign rdata_o     = rdata_reg;
  assign err_o       = err_reg;
  assign acc_start_o = acc_start_reg;
  assign busy_o      = run;
  assign irq_o       = done_reg && irq_en_reg;

endmodule

// File: tb/tb_acc_mat_bridge.sv
// Scoreboarded bench for acc_mat_bridge: directed scenarios then random bus/accelerator
// traffic, each response compared against a behavioural model of the register map.
module tb_acc_mat_bridge;
  localparam int          DW   = 8;
  localparam int          NE   = 16;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] CTRL_ADDR = BASE + NE - 2;
  localparam logic [31:0] STAT_ADDR = BASE + NE - 1;
  localparam logic [31:0] A_LO = BASE + NE;
  localparam logic [31:0] B_LO = BASE + 2 * NE;
  localparam logic [31:0] C_LO = BASE + 3 * NE;
  localparam logic [31:0] DMASK = (32'd1 << DW) - 32'd1;

  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, acc_done = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic gnt, rvalid, err, acc_start, busy, irq;
  logic [31:0] rdata;
  logic [NE*DW-1:0] in_a, in_b, acc_out = '0;

  acc_mat_bridge #(.DATA_W(DW), .N_ELEM(NE), .ADDR_W(AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .acc_start_o(acc_start), .acc_done_i(acc_done),
    .acc_in_a_o(in_a), .acc_in_b_o(in_b), .acc_out_i(acc_out),
    .busy_o(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks_total = 0, checks_passed = 0, txn_count = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks_total++;
    if (act === want) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
  endfunction

  // Behavioural model: running/done/err flags and plain element arrays.
  int unsigned ma[NE], mb[NE], mc[NE];
  bit m_run, m_done, m_err, m_irq;

  function automatic void model_clear();
    for (int i = 0; i < NE; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    m_run = 0; m_done = 0; m_err = 0; m_irq = 0;
  endfunction

  function automatic void model_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er, output bit started);
    int unsigned off, region, ix;
    rd = '0; er = 1'b0; started = 1'b0;
    if (a < BASE || a >= BASE + 4 * NE) begin er = 1'b1; return; end
    off = a - BASE; region = off / NE; ix = off % NE;
    case (region)
      0: begin
        if (ix == NE - 2) begin
          if (!w) rd = {29'd0, m_irq, 2'b00};
          else begin
            m_irq = wd[2];
            if (wd[1]) begin m_done = 0; m_err = 0; end
            if (wd[0]) begin
              if (m_run) begin er = 1'b1; m_err = 1; end
              else begin m_run = 1; m_done = 0; started = 1'b1; end
            end
          end
        end else if (ix == NE - 1) begin
          if (w) er = 1'b1;
          else rd = {29'd0, m_err, m_done, m_run};
        end else er = 1'b1;
      end
      1: if (w) begin if (m_run) er = 1'b1; else ma[ix] = wd & DMASK; end else rd = ma[ix];
      2: if (w) begin if (m_run) er = 1'b1; else mb[ix] = wd & DMASK; end else rd = mb[ix];
      default: if (w) er = 1'b1; else rd = mc[ix];
    endcase
  endfunction

  function automatic logic [NE*DW-1:0] pack_model(input bit sel_b);
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(sel_b ? mb[i] : ma[i]);
    return v;
  endfunction

  typedef struct { logic [31:0] rdata; logic err; string nm; } exp_t;
  exp_t exp_q[$];

  // Monitor: every rvalid pops one expectation; a missing rvalid is also a miss.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rvalid) begin
      txn_count++;
      if (exp_q.size() == 0) chk("rvalid without request", rvalid, 1'b0);
      else begin
        e = exp_q.pop_front();
        $display("txn %0d %s rdata=0x%08h err=%0b", txn_count, e.nm, rdata, err);
        chk({e.nm, " rdata"}, rdata, e.rdata);
        chk({e.nm, " err"}, err, e.err);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.nm, " rvalid"}, rvalid, 1'b1);
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] wd, input string nm);
    exp_t e;
    bit started;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    #1 chk({nm, " gnt"}, gnt, 1'b1);
    model_access(w, a, wd, e.rdata, e.err, started);
    e.nm = nm;
    @(posedge clk);
    exp_q.push_back(e);
    #1 req = 1'b0; we = 1'b0;
    chk({nm, " start"}, acc_start, started);
    chk({nm, " busy"}, busy, m_run);
    chk({nm, " irq"}, irq, m_done & m_irq);
  endtask

  task automatic acc_finish(input logic [NE*DW-1:0] p);
    @(negedge clk);
    acc_done = 1'b1; acc_out = p;
    if (m_run) begin
      for (int i = 0; i < NE; i++) mc[i] = p[i*DW +: DW];
      m_done = 1; m_run = 0;
    end
    @(posedge clk);
    #1 acc_done = 1'b0;
    $display("txn acc_done pattern=0x%0h", p);
    chk("acc_done busy", busy, m_run);
    chk("acc_done irq", irq, m_done & m_irq);
  endtask

  task automatic check_vectors(input string nm);
    chk({nm, " acc_in_a"}, in_a, pack_model(1'b0));
    chk({nm, " acc_in_b"}, in_b, pack_model(1'b1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; acc_done = 1'b0;
    @(posedge clk);
    #1;
    chk("reset rvalid", rvalid, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset start", acc_start, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset irq", irq, 1'b0);
    chk("reset acc_in_a", in_a, '0);
    chk("reset acc_in_b", in_b, '0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  function automatic logic [NE*DW-1:0] rand_pattern();
    logic [NE*DW-1:0] p;
    for (int i = 0; i < NE; i++) p[i*DW +: DW] = DW'($urandom);
    return p;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [NE*DW-1:0] p;
    int kind, ix;
    logic [31:0] d;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state reads
    bus(0, STAT_ADDR, 0, "rd STAT after reset");
    bus(0, A_LO, 0, "rd A0 after reset");
    bus(0, C_LO + NE - 1, 0, "rd C last after reset");

    // Operand writes truncate to DATA_W
    bus(1, A_LO + 5, 32'h1A5, "wr A5");
    bus(1, B_LO + NE - 1, 32'h3C, "wr B last");
    chk("A5 element", in_a[5*DW +: DW], 8'hA5);
    chk("B last element", in_b[(NE-1)*DW +: DW], 8'h3C);
    bus(0, A_LO + 5, 0, "rd A5");

    // Start with IRQ enabled, complete, poll, clear
    bus(1, CTRL_ADDR, 32'h5, "wr CTRL start+irq_en");
    @(posedge clk);
    #1 chk("start pulse width", acc_start, 1'b0);
    chk("busy during run", busy, 1'b1);
    p = rand_pattern();
    p[3*DW +: DW] = 8'h7E;
    acc_finish(p);
    bus(0, STAT_ADDR, 0, "rd STAT after done");
    bus(0, C_LO + 3, 0, "rd C3");
    chk("irq after done", irq, 1'b1);
    bus(0, CTRL_ADDR, 0, "rd CTRL");
    bus(1, CTRL_ADDR, 32'h6, "wr CTRL clr");
    chk("irq after clear", irq, 1'b0);

    // Errors during RUN
    bus(1, CTRL_ADDR, 32'h1, "wr CTRL start");
    bus(1, A_LO, 32'h11, "wr A0 during run");
    bus(1, CTRL_ADDR, 32'h1, "wr CTRL start during run");
    bus(0, A_LO, 0, "rd A0 during run");
    bus(0, STAT_ADDR, 0, "rd STAT sticky err");
    chk("A0 unchanged", in_a[0 +: DW], 8'h00);
    acc_finish(rand_pattern());

    // Unmapped and C-region writes
    bus(0, BASE + 4 * NE, 0, "rd past end");
    bus(1, C_LO, 32'hFF, "wr C0");
    bus(0, C_LO, 0, "rd C0");
    bus(0, BASE, 0, "rd below CTRL");

    // Re-run from DONE, then reset mid-run and a stale acc_done
    bus(1, CTRL_ADDR, 32'h3, "wr CTRL clr+start");
    do_reset();
    acc_finish(rand_pattern());
    bus(0, STAT_ADDR, 0, "rd STAT after mid-run reset");
    bus(0, C_LO + 3, 0, "rd C3 after mid-run reset");
    check_vectors("after mid-run reset");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      kind = $urandom_range(0, 9);
      ix = $urandom_range(0, NE - 1);
      d = $urandom;
      case (kind)
        0: bus(1, A_LO + ix, d, "rnd wr A");
        1: bus(1, B_LO + ix, d, "rnd wr B");
        2: bus(0, (d[4] ? B_LO : A_LO) + ix, 0, "rnd rd A/B");
        3: bus(0, C_LO + ix, 0, "rnd rd C");
        4: bus(1, CTRL_ADDR, {29'd0, d[2:0]}, "rnd wr CTRL");
        5: bus(0, d[0] ? STAT_ADDR : CTRL_ADDR, 0, "rnd rd CTRL/STAT");
        6: begin
          case (d[9:8])
            2'd0: bus(d[10], BASE - 1 - (d % 16), d, "rnd below base");
            2'd1: bus(d[10], BASE + (d % (NE - 2)), d, "rnd reserved");
            2'd2: bus(d[10], BASE + 4 * NE + (d % 64), d, "rnd past end");
            default: bus(1, d[11] ? STAT_ADDR : C_LO + ix, d, "rnd wr read-only");
          endcase
        end
        7, 8: acc_finish(rand_pattern());
        default: check_vectors("rnd");
      endcase
    end

    bus(0, STAT_ADDR, 0, "final STAT");
    check_vectors("final");
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
